// File: rtl/muldiv_pkg.sv
// Shared types and constants for the HI/LO multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIXUP
  } muldiv_state_t;

  // LO after a divide by zero; sliced to WIDTH by the unit.
  localparam logic [63:0] DIV0_LO = '1;

  function automatic logic op_is_signed(input muldiv_op_t op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// E/D-stage signal bundle between the pipeline and the multiply/divide unit.
interface muldiv_unit_if #(parameter int WIDTH = 32);
  logic             startE;
  logic [1:0]       opE;
  logic [WIDTH-1:0] srcaE;
  logic [WIDTH-1:0] srcbE;
  logic             mthiE;
  logic             mtloE;
  logic             mdopD;
  logic             mfD;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             mdstallD;

  modport master (
    output startE, opE, srcaE, srcbE, mthiE, mtloE, mdopD, mfD,
    input  hi, lo, busy, mdstallD
  );

  modport slave (
    input  startE, opE, srcaE, srcbE, mthiE, mtloE, mdopD, mfD,
    output hi, lo, busy, mdstallD
  );
endinterface

// File: rtl/muldiv_step.sv
// One iteration of the magnitude datapath: shift-add multiply or restoring divide.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             mode_div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] qr,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] qr_next
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;

  always_comb begin
    sum      = {1'b0, acc} + (qr[0] ? {1'b0, opnd} : '0);
    shifted  = {acc, qr[WIDTH-1]};
    // Partial remainder stays below the divisor, so a WIDTH-bit difference suffices.
    diff     = shifted[WIDTH-1:0] - opnd;
    acc_next = sum[WIDTH:1];
    qr_next  = {sum[0], qr[WIDTH-1:1]};
    if (mode_div) begin
      if (shifted >= {1'b0, opnd}) begin
        acc_next = diff;
        qr_next  = {qr[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = shifted[WIDTH-1:0];
        qr_next  = {qr[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit with D-stage stall request.
// Define MULDIV_FAST_MULT_EN for single-cycle combinational multiplies.
//
// state    | meaning
// ST_IDLE  | waiting; mthi/mtlo writes and op capture
// ST_MUL   | shift-add, one multiplier bit per cycle
// ST_DIV   | restoring subtract, one quotient bit per cycle
// ST_FIXUP | apply signs, write HI/LO
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic          clk,
  input logic          reset,
  muldiv_unit_if.slave md
);

  localparam int CW = $clog2(WIDTH);

  muldiv_state_t      state, state_next;
  muldiv_op_t         op;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   acc, qr, opnd, hi_q, lo_q;
  logic [WIDTH-1:0]   acc_next, qr_next, abs_a, abs_b, quot_fix, rem_fix;
  logic [2*WIDTH-1:0] prod_raw, prod_fix, fast_prod;
  logic               is_div, res_neg, rem_neg, dz, sgn, fast_mul, start_iter;

  assign op    = muldiv_op_t'(md.opE);
  assign sgn   = op_is_signed(op);
  assign abs_a = (sgn && md.srcaE[WIDTH-1]) ? -md.srcaE : md.srcaE;
  assign abs_b = (sgn && md.srcbE[WIDTH-1]) ? -md.srcbE : md.srcbE;

`ifdef MULDIV_FAST_MULT_EN
  logic [2*WIDTH-1:0] ext_a, ext_b;
  assign ext_a     = {{WIDTH{sgn & md.srcaE[WIDTH-1]}}, md.srcaE};
  assign ext_b     = {{WIDTH{sgn & md.srcbE[WIDTH-1]}}, md.srcbE};
  assign fast_prod = ext_a * ext_b;
  assign fast_mul  = ~md.opE[1];
`else
  assign fast_prod = '0;
  assign fast_mul  = 1'b0;
`endif

  assign start_iter = md.startE && (state == ST_IDLE) && !fast_mul;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .mode_div (is_div),
    .acc      (acc),
    .qr       (qr),
    .opnd     (opnd),
    .acc_next (acc_next),
    .qr_next  (qr_next)
  );

  assign prod_raw = {acc, qr};
  assign prod_fix = res_neg ? -prod_raw : prod_raw;
  assign quot_fix = dz ? DIV0_LO[WIDTH-1:0] : (res_neg ? -qr : qr);
  assign rem_fix  = rem_neg ? -acc : acc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:        if (start_iter) state_next = md.opE[1] ? ST_DIV : ST_MUL;
      ST_MUL, ST_DIV: if (cnt == '0) state_next = ST_FIXUP;
      ST_FIXUP:       state_next = ST_IDLE;
      default:        state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      acc     <= '0;
      qr      <= '0;
      opnd    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      is_div  <= 1'b0;
      res_neg <= 1'b0;
      rem_neg <= 1'b0;
      dz      <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start_iter) begin
            acc     <= '0;
            qr      <= abs_a;
            opnd    <= abs_b;
            is_div  <= md.opE[1];
            res_neg <= sgn & (md.srcaE[WIDTH-1] ^ md.srcbE[WIDTH-1]);
            rem_neg <= sgn & md.srcaE[WIDTH-1];
            dz      <= (md.srcbE == '0);
            cnt     <= CW'(WIDTH - 1);
          end else if (md.startE) begin
            hi_q <= fast_prod[2*WIDTH-1:WIDTH];
            lo_q <= fast_prod[WIDTH-1:0];
          end else begin
            if (md.mthiE) hi_q <= md.srcaE;
            if (md.mtloE) lo_q <= md.srcaE;
          end
        end
        ST_MUL, ST_DIV: begin
          acc <= acc_next;
          qr  <= qr_next;
          cnt <= cnt - 1'b1;
        end
        ST_FIXUP: begin
          if (is_div) begin
            hi_q <= rem_fix;
            lo_q <= quot_fix;
          end else begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign md.hi       = hi_q;
  assign md.lo       = lo_q;
  assign md.busy     = (state != ST_IDLE);
  // Holds back mf*/md ops in D until E-stage HI/LO traffic has drained.
  assign md.mdstallD = (md.mdopD | md.mfD) & (md.busy | md.startE | md.mthiE | md.mtloE);

endmodule
